// File: rtl/axi_regbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_regbus_arbiter
// Brief    : Round-robin arbiter/sequencer for a shared 32-bit register bus
//            with per-access timeout and registered completion signalling.
// Revision : 1.0 - initial release
// ============================================================================
module axi_regbus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CW          = 16
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_we,
    input  logic [N_REQ*32-1:0]   i_addr,
    input  logic [N_REQ*32-1:0]   i_wdata,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic [2:0]            o_gnt_id,
    output logic                  o_busy,
    output logic                  o_cs,
    output logic                  o_we,
    output logic [31:0]           o_addr,
    output logic [31:0]           o_data,
    input  logic [31:0]           i_data,
    input  logic                  i_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LAST_RST = 3'(N_REQ - 1);
    localparam logic [31:0]   ERR_DATA = 32'hDEAD_BEEF;

    state_t             state, state_nx;
    logic [2:0]         last, last_nx;
    logic [CW-1:0]      cnt, cnt_nx;

    logic [N_REQ-1:0]   ack_nx;
    logic               err_nx;
    logic [31:0]        rdata_nx;
    logic [2:0]         gnt_nx;
    logic               busy_nx;
    logic               cs_nx;
    logic               we_nx;
    logic [31:0]        addr_nx;
    logic [31:0]        data_nx;

    logic [N_REQ-1:0]   above;
    logic [N_REQ-1:0]   cand;
    logic [2:0]         win;
    logic               win_we;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic [N_REQ-1:0]   gnt_onehot;

    // Round-robin pick: lowest requester above the pointer, else lowest overall.
    always_comb begin
        above = '0;
        for (int k = 0; k < N_REQ; k++) begin
            above[k] = (k > int'(last));
        end
        cand = ((i_req & above) != '0) ? (i_req & above) : i_req;
        win  = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win = 3'(k);
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = 32'd0;
        win_wdata = 32'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (3'(k) == win) begin
                win_we    = i_we[k];
                win_addr  = i_addr[k*32 +: 32];
                win_wdata = i_wdata[k*32 +: 32];
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt_onehot[k] = (3'(k) == o_gnt_id);
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        ack_nx   = '0;
        err_nx   = 1'b0;
        rdata_nx = o_rdata;
        gnt_nx   = o_gnt_id;
        busy_nx  = o_busy;
        cs_nx    = o_cs;
        we_nx    = o_we;
        addr_nx  = o_addr;
        data_nx  = o_data;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                cs_nx   = 1'b0;
                if (i_req != '0) begin
                    gnt_nx   = win;
                    we_nx    = win_we;
                    addr_nx  = win_addr;
                    data_nx  = win_wdata;
                    cs_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (i_ready) begin
                    if (!o_we) begin
                        rdata_nx = i_data;
                    end
                    cs_nx    = 1'b0;
                    ack_nx   = gnt_onehot;
                    state_nx = DONE;
                end else if (cnt == TMO_LAST) begin
                    cs_nx    = 1'b0;
                    rdata_nx = ERR_DATA;
                    ack_nx   = gnt_onehot;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                // The just-served requester drops to lowest priority.
                last_nx  = o_gnt_id;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state    <= IDLE;
            last     <= LAST_RST;
            cnt      <= '0;
            o_ack    <= '0;
            o_err    <= 1'b0;
            o_rdata  <= 32'd0;
            o_gnt_id <= 3'd0;
            o_busy   <= 1'b0;
            o_cs     <= 1'b0;
            o_we     <= 1'b0;
            o_addr   <= 32'd0;
            o_data   <= 32'd0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            cnt      <= cnt_nx;
            o_ack    <= ack_nx;
            o_err    <= err_nx;
            o_rdata  <= rdata_nx;
            o_gnt_id <= gnt_nx;
            o_busy   <= busy_nx;
            o_cs     <= cs_nx;
            o_we     <= we_nx;
            o_addr   <= addr_nx;
            o_data   <= data_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_regbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_regbus_arbiter
// Brief    : Scoreboard bench for axi_regbus_arbiter with a programmable slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_regbus_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            i_aresetn;
    logic [N-1:0]    i_req;
    logic [N-1:0]    i_we;
    logic [N*32-1:0] i_addr;
    logic [N*32-1:0] i_wdata;
    logic [N-1:0]    o_ack;
    logic            o_err;
    logic [31:0]     o_rdata;
    logic [2:0]      o_gnt_id;
    logic            o_busy;
    logic            o_cs;
    logic            o_we;
    logic [31:0]     o_addr;
    logic [31:0]     o_data;
    logic [31:0]     i_data;
    logic            i_ready;

    axi_regbus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(8), .CW(16)) dut (
        .i_aclk(clk), .i_aresetn(i_aresetn),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_gnt_id(o_gnt_id),
        .o_busy(o_busy), .o_cs(o_cs), .o_we(o_we), .o_addr(o_addr),
        .o_data(o_data), .i_data(i_data), .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [2:0]  id;
        logic        err;
        logic [31:0] rdata;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];
    int   rises[$];

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int cyc      = 0;
    int last_cs_len = 0;

    int          lat = 0;
    logic [31:0] slave_data = 32'd0;
    logic        force_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic set_req(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        i_we[k]            = we;
        i_addr[k*32 +: 32]  = addr;
        i_wdata[k*32 +: 32] = wdata;
    endtask

    task automatic push_bus(input logic [2:0] id, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
        bus_t b;
        b.id = id; b.we = we; b.addr = addr; b.data = data;
        exp_bus.push_back(b);
    endtask

    task automatic push_ack(input logic [2:0] id, input logic err, input logic [31:0] rdata);
        ack_t a;
        a.id = id; a.err = err; a.rdata = rdata;
        exp_ack.push_back(a);
    endtask

    task automatic wait_acks(input int n);
        int target;
        int t;
        target = ack_cnt + n;
        t = 0;
        while (ack_cnt < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ack_cnt < target) fail_now("ack_wait_expired");
    endtask

    // Slave: ready after 'lat' cycles of cs (lat<0 never); otherwise drives force_ready.
    initial begin
        int age;
        age = 0;
        i_ready = 1'b0;
        i_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (o_cs) begin
                i_ready = (age == lat);
                i_data  = slave_data;
                age++;
            end else begin
                i_ready = force_ready;
                age = 0;
            end
        end
    end

    // Monitor: checks bus launches, bus stability and completions against queues.
    initial begin
        logic        prev_cs;
        logic        cap_we;
        logic [31:0] cap_addr;
        logic [31:0] cap_data;
        int          cs_run;
        bus_t        b;
        ack_t        a;
        prev_cs = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_data = '0; cs_run = 0;
        forever begin
            @(negedge clk);
            if (o_cs && !prev_cs) begin
                rises.push_back(cyc);
                if (exp_bus.size() == 0) begin
                    fail_now("bus_unexpected");
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_gnt",  32'(o_gnt_id), 32'(b.id));
                    chk("bus_we",   32'(o_we),     32'(b.we));
                    chk("bus_addr", o_addr,        b.addr);
                    chk("bus_data", o_data,        b.data);
                end
                cap_we = o_we; cap_addr = o_addr; cap_data = o_data;
                cs_run = 0;
            end else if (o_cs && prev_cs) begin
                chk("bus_stable", 32'(o_we == cap_we && o_addr == cap_addr && o_data == cap_data), 32'd1);
            end
            if (o_cs) cs_run++;
            else if (prev_cs) last_cs_len = cs_run;
            if (o_ack != '0) begin
                ack_cnt++;
                if (exp_ack.size() == 0) begin
                    fail_now("ack_unexpected");
                end else begin
                    a = exp_ack.pop_front();
                    chk("ack_vec",   32'(o_ack), 32'(4'b0001 << a.id));
                    chk("ack_err",   32'(o_err), 32'(a.err));
                    chk("ack_rdata", o_rdata,    a.rdata);
                end
            end
            prev_cs = o_cs;
            cyc++;
        end
    end

    initial begin
        int t;
        i_aresetn = 1'b1;
        i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        #1 i_aresetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs",    32'(o_cs),     32'd0);
        chk("rst_ack",   32'(o_ack),    32'd0);
        chk("rst_err",   32'(o_err),    32'd0);
        chk("rst_rdata", o_rdata,       32'd0);
        chk("rst_gnt",   32'(o_gnt_id), 32'd0);
        chk("rst_busy",  32'(o_busy),   32'd0);
        chk("rst_addr",  o_addr,        32'd0);
        i_aresetn = 1'b1;
        @(negedge clk);

        // Round-robin fairness with an immediate-ready slave.
        set_req(0, 1'b1, 32'h0000_0100, 32'h1111_0000);
        set_req(1, 1'b0, 32'h0000_0104, 32'h0);
        set_req(2, 1'b1, 32'h0000_0108, 32'h2222_0000);
        set_req(3, 1'b0, 32'h0000_010C, 32'h0);
        slave_data = 32'h5555_AAAA; lat = 0;
        rises.delete();
        push_bus(0, 1, 32'h100, 32'h1111_0000); push_ack(0, 0, 32'h0000_0000);
        push_bus(1, 0, 32'h104, 32'h0);         push_ack(1, 0, 32'h5555_AAAA);
        push_bus(2, 1, 32'h108, 32'h2222_0000); push_ack(2, 0, 32'h5555_AAAA);
        push_bus(3, 0, 32'h10C, 32'h0);         push_ack(3, 0, 32'h5555_AAAA);
        push_bus(0, 1, 32'h100, 32'h1111_0000); push_ack(0, 0, 32'h5555_AAAA);
        push_bus(1, 0, 32'h104, 32'h0);         push_ack(1, 0, 32'h5555_AAAA);
        i_req = 4'b1111;
        wait_acks(6);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);
        if (rises.size() >= 6) begin
            for (int i = 0; i < 5; i++) chk("rr_gap", 32'(rises[i+1] - rises[i]), 32'd3);
        end else begin
            fail_now("rr_missing_grants");
        end

        // Single read, ready during the first cs cycle.
        set_req(1, 1'b0, 32'h0000_0040, 32'h0);
        slave_data = 32'h1234_5678; lat = 0;
        push_bus(1, 0, 32'h40, 32'h0); push_ack(1, 0, 32'h1234_5678);
        i_req = 4'b0010;
        wait_acks(1);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("read_cs_len", 32'(last_cs_len), 32'd1);

        // Write with wait states; read data register must not change.
        set_req(2, 1'b1, 32'h0000_0010, 32'hCAFE_0001);
        slave_data = 32'hFFFF_0000; lat = 4;
        push_bus(2, 1, 32'h10, 32'hCAFE_0001); push_ack(2, 0, 32'h1234_5678);
        i_req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("write_busy", 32'(o_busy), 32'd1);
        chk("write_we",   32'(o_we),   32'd1);
        wait_acks(1);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("write_cs_len", 32'(last_cs_len), 32'd5);

        // Timeout on requester 3, then pending requester 0 is served.
        set_req(3, 1'b0, 32'h0000_0030, 32'h0);
        set_req(0, 1'b0, 32'h0000_0020, 32'h0);
        slave_data = 32'h0000_00A0; lat = -1;
        push_bus(3, 0, 32'h30, 32'h0); push_ack(3, 1, 32'hDEAD_BEEF);
        push_bus(0, 0, 32'h20, 32'h0); push_ack(0, 0, 32'h0000_00A0);
        i_req = 4'b1001;
        wait_acks(1);
        i_req = 4'b0001; lat = 0;
        @(negedge clk);
        chk("tmo_cs_len", 32'(last_cs_len), 32'd8);
        wait_acks(1);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Request arriving mid-access waits; stray ready with cs low is ignored.
        set_req(0, 1'b0, 32'h0000_0050, 32'h0);
        set_req(3, 1'b1, 32'h0000_0060, 32'h3333_3333);
        slave_data = 32'h7777_0000; lat = 6;
        rises.delete();
        push_bus(0, 0, 32'h50, 32'h0);         push_ack(0, 0, 32'h7777_0000);
        push_bus(3, 1, 32'h60, 32'h3333_3333); push_ack(3, 0, 32'h7777_0000);
        i_req = 4'b0001;
        repeat (3) @(negedge clk);
        i_req = 4'b1001;
        wait_acks(1);
        i_req = 4'b1000; lat = 1; force_ready = 1'b1;
        repeat (2) @(negedge clk);
        force_ready = 1'b0;
        wait_acks(1);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);
        if (rises.size() >= 2) chk("midreq_gap", 32'(rises[1] - rises[0]), 32'd9);
        else fail_now("midreq_missing_grant");

        // Move the pointer to 2 so a pointer that survives reset would pick 3.
        set_req(2, 1'b1, 32'h0000_0090, 32'h0000_0009);
        lat = 0;
        push_bus(2, 1, 32'h90, 32'h9); push_ack(2, 0, 32'h7777_0000);
        i_req = 4'b0100;
        wait_acks(1);
        i_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset in the middle of an access.
        set_req(1, 1'b0, 32'h0000_0070, 32'h0);
        lat = -1;
        push_bus(1, 0, 32'h70, 32'h0);
        i_req = 4'b0010;
        t = 0;
        while (!o_cs && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!o_cs) fail_now("cs_wait_expired");
        repeat (2) @(negedge clk);
        i_aresetn = 1'b0;
        #1;
        chk("arst_cs",    32'(o_cs),     32'd0);
        chk("arst_ack",   32'(o_ack),    32'd0);
        chk("arst_busy",  32'(o_busy),   32'd0);
        chk("arst_rdata", o_rdata,       32'd0);
        chk("arst_gnt",   32'(o_gnt_id), 32'd0);
        @(negedge clk);
        set_req(3, 1'b0, 32'h0000_0080, 32'h0);
        slave_data = 32'h4444_0001; lat = 0;
        push_bus(1, 0, 32'h70, 32'h0); push_ack(1, 0, 32'h4444_0001);
        push_bus(3, 0, 32'h80, 32'h0); push_ack(3, 0, 32'h4444_0001);
        i_req = 4'b1010;
        @(negedge clk);
        i_aresetn = 1'b1;
        wait_acks(1);
        i_req = 4'b1000;
        wait_acks(1);
        i_req = 4'b0000;
        repeat (3) @(negedge clk);

        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_regbus_arbiter.md
Name: axi_regbus_arbiter

Overview:
- Round-robin arbiter and sequencer for the single 32-bit register bus (cs/addr/data) on the back side of the AXI slave bridges.
- Lets up to N_REQ requesters share one register bus, for example the AXI read path, the AXI write path and debug/config masters.
- Serializes their accesses, enforces a bus timeout, and returns read data and completion status to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 255, maximum cycles in ACCESS waiting for i_ready before error completion (1..65535).
- CW, 16, width of the internal timeout counter; must hold TIMEOUT_CYC.

Ports:
- i_aclk  input  1  clock.
- i_aresetn  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  per-requester access request, level.
- i_we  input  N_REQ  per-requester write enable (1=write, 0=read).
- i_addr  input  N_REQ*32  per-requester address; requester k uses bits [32k+31:32k].
- i_wdata  input  N_REQ*32  per-requester write data, same packing.
- o_ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- o_err  output  1  valid with o_ack; 1 = access timed out.
- o_rdata  output  32  read data, valid with o_ack on a read.
- o_gnt_id  output  3  index of the current or last granted requester.
- o_busy  output  1  high in ACCESS and DONE.
- o_cs  output  1  register bus chip select.
- o_we  output  1  register bus write enable.
- o_addr  output  32  register bus address.
- o_data  output  32  register bus write data.
- i_data  input  32  register bus read data.
- i_ready  input  1  register bus completion, sampled only while o_cs=1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0, including o_rdata and o_gnt_id.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - Timeout counter 0.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any i_req bit is high, select the first set bit searching last+1, last+2, ... with wrap modulo N_REQ.
  - Latch idx, we, addr and wdata of the winner. Drive o_cs=1 and o_we/o_addr/o_data from the latch, and o_gnt_id=idx. Clear the counter. Next state ACCESS.
  - If no request, stay in IDLE with o_cs=0.
- ACCESS:
  - o_cs, o_we, o_addr and o_data are held stable. Requester inputs are ignored, and requests arriving now wait.
  - i_ready=1: capture i_data into o_rdata if latched we=0; if we=1, o_rdata is unchanged. Deassert o_cs, pulse o_ack[idx]=1 with o_err=0, and go to DONE.
  - Else, if counter==TIMEOUT_CYC-1: deassert o_cs, set o_rdata=32'hDEAD_BEEF, pulse o_ack[idx]=1 with o_err=1, and go to DONE.
  - Else increment the counter.
- DONE: o_ack=0, o_err=0, last=idx. Next state IDLE.
- Minimum access timing:
  - Request seen at edge E0 -> o_cs high after E0.
  - i_ready high before E1 -> o_ack high after E1 for exactly one cycle.
  - IDLE after E2; next grant at E3, giving 3 cycles per access.
- Requester contract:
  - Hold i_req and the request fields until o_ack.
  - i_req still high in the cycle after o_ack is a new request; it gets lowest priority because last=idx.
  - A requester dropping i_req while granted does not abort the access; it still completes and acks.
- i_ready while o_cs=0 is ignored.
- o_gnt_id keeps the last granted index while idle.
- Reset asserted mid-ACCESS: o_cs drops immediately (async), no ack is produced, and the pointer returns to N_REQ-1.

Test Plan:
- Single read: req[1]=1, we=0, addr=32'h0000_0040; slave returns i_ready one cycle after cs with i_data=32'h1234_5678 -> o_cs high for 1 cycle, o_ack=4'b0010 after E1, o_rdata=32'h1234_5678, o_err=0.
- Round-robin fairness: i_req=4'b1111 held continuously with an immediate-ready slave -> grant order 0,1,2,3,0,1; each o_ack one cycle wide; a new o_cs rising edge every 3 cycles.
- Write with wait states: req[2] write, addr=32'h10, wdata=32'hCAFE_0001; i_ready after 5 cycles -> o_we=1, o_addr and o_data stable all 5 cycles; o_rdata unchanged; o_ack[2] pulses once.
- Timeout: TIMEOUT_CYC=8, i_ready never asserted -> o_cs high exactly 8 cycles, then o_ack[idx]=1 with o_err=1 and o_rdata=32'hDEAD_BEEF; the arbiter then serves the next pending requester.
- Requests during access: req[0] is in ACCESS and req[3] rises mid-access -> req[3] is not granted until after DONE; a late i_ready arriving after o_cs has dropped has no effect.
- Reset mid-access: assert i_aresetn=0 while o_cs=1 -> o_cs, o_ack, o_busy and o_rdata become 0 without waiting for a clock edge; after release with i_req=4'b1010, requester 1 is granted first.
